// File: rtl/string_hw_pkg.sv
// Shared constants for the string-compare accelerator: register map, bit
// positions, FSM states and the byte-prefix helper used by the compare step.
package string_hw_pkg;

  localparam logic [2:0] ADDR_FIFO_A  = 3'd0;
  localparam logic [2:0] ADDR_FIFO_B  = 3'd1;
  localparam logic [2:0] ADDR_CONTROL = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_RESULT  = 3'd4;

  localparam int CTRL_DONE_BIT  = 0;
  localparam int CTRL_BUSY_BIT  = 1;
  localparam int CTRL_GO_BIT    = 1;
  localparam int CTRL_CLEAR_BIT = 2;
  localparam int CTRL_LEN_LSB   = 8;
  localparam int LEN_W          = 8;

  localparam int ST_B_CNT_LSB     = 16;
  localparam int ST_OVERFLOW_BIT  = 12;
  localparam int ST_UNDERFLOW_BIT = 13;
  localparam int ST_A_EMPTY_BIT   = 14;
  localparam int ST_A_FULL_BIT    = 15;
  localparam int ST_B_EMPTY_BIT   = 30;
  localparam int ST_B_FULL_BIT    = 31;

  localparam int RES_EQUAL_BIT = 31;
  localparam int MATCH_W       = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CMP,
    S_FIN
  } state_t;

  // Number of equal bytes counted from byte 3 down, stopping at the first difference.
  function automatic logic [2:0] lead_eq_bytes(input logic [31:0] a, input logic [31:0] b);
    logic [2:0] n;
    logic       run;
    n   = 3'd0;
    run = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (run && (a[8*i +: 8] == b[8*i +: 8])) n = n + 3'd1;
      else run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/string_fifo_accel_if.sv
// Avalon-MM slave bus bundle for the string-compare accelerator.
interface string_fifo_accel_if;
  logic        chipselect;
  logic [2:0]  address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output chipselect, address, write, read, writedata, input readdata);
  modport slave  (input chipselect, address, write, read, writedata, output readdata);
endinterface

// File: rtl/str_fifo.sv
// 32-bit synchronous FIFO with occupancy count; a push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module str_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage has no reset so it maps onto RAM; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/string_fifo_accel.sv
// Avalon-MM string-compare accelerator: two word FIFOs feed a byte-wise
// MSB-first comparator that reports the matching-prefix length and equality.
module string_fifo_accel #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic                clk,
  input logic                reset_n,
  string_fifo_accel_if.slave bus
);

  import string_hw_pkg::*;

  state_t             state;
  logic               busy;
  logic               done;
  logic               overflow;
  logic               underflow;
  logic               equal;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   rem_words;
  logic [MATCH_W-1:0] match;
  logic [31:0]        word_a;
  logic [31:0]        word_b;
  logic [31:0]        readdata_q;
  logic [31:0]        rd_mux;
  logic [31:0]        status_word;

  logic [31:0]      head_a, head_b;
  logic             full_a, full_b, empty_a, empty_b;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  logic             wr_en, rd_en, ctrl_wr, clear_cmd, go_cmd;
  logic             push_a, push_b, host_pop_a, host_pop_b, eng_pop, pop_a, pop_b;
  logic [LEN_W-1:0] go_len;
  logic [2:0]       lead_n;

  assign wr_en      = bus.chipselect && bus.write;
  assign rd_en      = bus.chipselect && bus.read;
  assign ctrl_wr    = wr_en && (bus.address == ADDR_CONTROL);
  assign clear_cmd  = ctrl_wr && bus.writedata[CTRL_CLEAR_BIT];
  assign go_cmd     = ctrl_wr && bus.writedata[CTRL_GO_BIT] && !clear_cmd;
  assign go_len     = bus.writedata[CTRL_LEN_LSB +: LEN_W];

  // Host pops are suppressed while the engine owns the FIFOs; pushes always go through.
  assign push_a     = wr_en && (bus.address == ADDR_FIFO_A);
  assign push_b     = wr_en && (bus.address == ADDR_FIFO_B);
  assign host_pop_a = rd_en && (bus.address == ADDR_FIFO_A) && !busy;
  assign host_pop_b = rd_en && (bus.address == ADDR_FIFO_B) && !busy;
  assign eng_pop    = (state == S_FETCH) && !empty_a && !empty_b;
  assign pop_a      = host_pop_a || eng_pop;
  assign pop_b      = host_pop_b || eng_pop;
  assign lead_n     = lead_eq_bytes(word_a, word_b);

  assign bus.readdata = readdata_q;

  str_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_a (
    .clk(clk), .reset_n(reset_n), .clear(clear_cmd), .push(push_a), .pop(pop_a),
    .wdata(bus.writedata), .rdata(head_a), .full(full_a), .empty(empty_a), .count(cnt_a)
  );

  str_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo_b (
    .clk(clk), .reset_n(reset_n), .clear(clear_cmd), .push(push_b), .pop(pop_b),
    .wdata(bus.writedata), .rdata(head_b), .full(full_b), .empty(empty_b), .count(cnt_b)
  );

  always_comb begin
    status_word                           = '0;
    status_word[CNT_W-1:0]                = cnt_a;
    status_word[ST_B_CNT_LSB +: CNT_W]    = cnt_b;
    status_word[ST_OVERFLOW_BIT]          = overflow;
    status_word[ST_UNDERFLOW_BIT]         = underflow;
    status_word[ST_A_EMPTY_BIT]           = empty_a;
    status_word[ST_A_FULL_BIT]            = full_a;
    status_word[ST_B_EMPTY_BIT]           = empty_b;
    status_word[ST_B_FULL_BIT]            = full_b;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_FIFO_A:  if (!busy && !empty_a) rd_mux = head_a;
      ADDR_FIFO_B:  if (!busy && !empty_b) rd_mux = head_b;
      ADDR_CONTROL: begin
        rd_mux[CTRL_DONE_BIT]          = done;
        rd_mux[CTRL_BUSY_BIT]          = busy;
        rd_mux[CTRL_LEN_LSB +: LEN_W]  = len;
      end
      ADDR_STATUS:  rd_mux = status_word;
      ADDR_RESULT: begin
        rd_mux[MATCH_W-1:0]   = match;
        rd_mux[RES_EQUAL_BIT] = equal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      equal      <= 1'b0;
      len        <= '0;
      rem_words  <= '0;
      match      <= '0;
      word_a     <= '0;
      word_b     <= '0;
      readdata_q <= '0;
    end else begin
      if (rd_en)   readdata_q <= rd_mux;
      if (ctrl_wr) len        <= go_len;

      if (clear_cmd) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
        equal     <= 1'b0;
        match     <= '0;
      end else begin
        if ((push_a && full_a && !pop_a) || (push_b && full_b && !pop_b)) overflow <= 1'b1;
        if ((host_pop_a && empty_a) || (host_pop_b && empty_b))           underflow <= 1'b1;

        case (state)
          S_IDLE: begin
            if (go_cmd) begin
              match <= '0;
              if (go_len != '0) begin
                done      <= 1'b0;
                busy      <= 1'b1;
                equal     <= 1'b0;
                rem_words <= go_len;
                state     <= S_FETCH;
              end else begin
                done  <= 1'b1;
                equal <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            if (eng_pop) begin
              word_a <= head_a;
              word_b <= head_b;
              state  <= S_CMP;
            end
          end
          S_CMP: begin
            match <= match + MATCH_W'(lead_n);
            if (lead_n != 3'd4) begin
              equal <= 1'b0;
              state <= S_FIN;
            end else if (rem_words == LEN_W'(1)) begin
              equal <= 1'b1;
              state <= S_FIN;
            end else begin
              rem_words <= rem_words - LEN_W'(1);
              state     <= S_FETCH;
            end
          end
          S_FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_string_fifo_accel.sv
// Self-checking bench for string_fifo_accel: directed scenarios plus randomized
// compares scored against a queue-based model of the register-level behaviour.
module tb_string_fifo_accel;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;
  localparam logic [31:0] ST_BOTH_EMPTY = 32'h4000_4000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  string_fifo_accel_if bus();

  string_fifo_accel #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = addr;
    bus.writedata  = data;
    @(posedge clk);
    #1 bus_idle();
  endtask

  task automatic rd(input logic [2:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    @(posedge clk);
    #1 bus_idle();
    data = bus.readdata;
  endtask

  task automatic do_reset();
    bus_idle();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Expected STATUS word built from the occupancy/flag field definitions.
  function automatic logic [31:0] exp_status(input int ca, input int cb, input bit ovf, input bit udf);
    logic [31:0] s;
    s = 32'(ca) | (32'(cb) << 16);
    if (ovf)         s = s | (32'd1 << 12);
    if (udf)         s = s | (32'd1 << 13);
    if (ca == 0)     s = s | (32'd1 << 14);
    if (ca == DEPTH) s = s | (32'd1 << 15);
    if (cb == 0)     s = s | (32'd1 << 30);
    if (cb == DEPTH) s = s | (32'd1 << 31);
    return s;
  endfunction

  task automatic wait_done(input string name);
    logic [31:0] c;
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      rd(3'd2, c);
      if (c[0]) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s_done_timeout: got no DONE within 64 reads, expected DONE=1", name);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    tests_run++;
    if (bus.readdata !== 32'd0) begin tests_failed++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'd0); end
    rd(3'd3, d); tests_run++;
    if (d !== ST_BOTH_EMPTY) begin tests_failed++; $display("FAIL reset_status: got %h expected %h", d, ST_BOTH_EMPTY); end
    rd(3'd2, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_control: got %h expected %h", d, 32'd0); end
    rd(3'd4, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL reset_result: got %h expected %h", d, 32'd0); end
    for (int a = 5; a < 8; a++) begin
      wr(3'(a), 32'hFFFF_FFFF);
      rd(3'(a), d); tests_run++;
      if (d !== 32'd0) begin tests_failed++; $display("FAIL unmapped_addr%0d: got %h expected %h", a, d, 32'd0); end
    end
  endtask

  task automatic test_equal_word();
    logic [31:0] d;
    logic [31:0] exp_ctrl;
    do_reset();
    wr(3'd0, 32'h4142_4344);
    wr(3'd1, 32'h4142_4344);
    wr(3'd2, 32'h0000_0102);
    // GO lands on edge 0; DONE rises on edge 3 and is seen by the read sampling edge 4.
    for (int k = 0; k < 4; k++) begin
      rd(3'd2, d);
      exp_ctrl = (k < 3) ? 32'h0000_0102 : 32'h0000_0101;
      tests_run++;
      if (d !== exp_ctrl) begin tests_failed++; $display("FAIL equal_latency_read%0d: got %h expected %h", k, d, exp_ctrl); end
    end
    rd(3'd4, d); tests_run++;
    if (d !== 32'h8000_0004) begin tests_failed++; $display("FAIL equal_result: got %h expected %h", d, 32'h8000_0004); end
    rd(3'd3, d); tests_run++;
    if (d !== ST_BOTH_EMPTY) begin tests_failed++; $display("FAIL equal_status: got %h expected %h", d, ST_BOTH_EMPTY); end
  endtask

  task automatic test_mismatch();
    logic [31:0] d;
    do_reset();
    wr(3'd0, 32'h4142_4344);
    wr(3'd1, 32'h4142_5844);
    wr(3'd2, 32'h0000_0102);
    wait_done("mismatch");
    rd(3'd4, d); tests_run++;
    if (d !== 32'h0000_0002) begin tests_failed++; $display("FAIL mismatch_result: got %h expected %h", d, 32'h0000_0002); end
  endtask

  task automatic test_len_zero();
    logic [31:0] d;
    wr(3'd2, 32'h0000_0002);
    rd(3'd2, d); tests_run++;
    if (d !== 32'h0000_0001) begin tests_failed++; $display("FAIL len0_control: got %h expected %h", d, 32'h0000_0001); end
    rd(3'd4, d); tests_run++;
    if (d !== 32'h8000_0000) begin tests_failed++; $display("FAIL len0_result: got %h expected %h", d, 32'h8000_0000); end
  endtask

  task automatic test_overflow_underflow();
    logic [31:0] d, w, e;
    logic [31:0] q[$];
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom;
      if (i < DEPTH) q.push_back(w);
      wr(3'd0, w);
    end
    rd(3'd3, d); tests_run++;
    e = exp_status(DEPTH, 0, 1'b1, 1'b0);
    if (d !== e) begin tests_failed++; $display("FAIL ovf_status: got %h expected %h", d, e); end
    for (int i = 0; i < DEPTH; i++) begin
      rd(3'd0, d);
      e = q.pop_front();
      tests_run++;
      if (d !== e) begin tests_failed++; $display("FAIL pop_order%0d: got %h expected %h", i, d, e); end
    end
    rd(3'd0, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL pop_empty_data: got %h expected %h", d, 32'd0); end
    rd(3'd3, d); tests_run++;
    e = exp_status(0, 0, 1'b1, 1'b1);
    if (d !== e) begin tests_failed++; $display("FAIL udf_status: got %h expected %h", d, e); end
  endtask

  task automatic test_fetch_wait();
    logic [31:0] d, w1, w2;
    do_reset();
    w1 = $urandom;
    w2 = $urandom;
    wr(3'd0, w1);
    wr(3'd1, w1);
    wr(3'd2, 32'h0000_0202);
    repeat (5) @(posedge clk);
    rd(3'd2, d); tests_run++;
    if (d !== 32'h0000_0202) begin tests_failed++; $display("FAIL fetch_wait_busy: got %h expected %h", d, 32'h0000_0202); end
    rd(3'd0, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL busy_pop_data: got %h expected %h", d, 32'd0); end
    rd(3'd3, d); tests_run++;
    if (d[13] !== 1'b0) begin tests_failed++; $display("FAIL busy_pop_underflow: got %b expected %b", d[13], 1'b0); end
    wr(3'd0, w2);
    wr(3'd1, w2);
    wait_done("fetch_wait");
    rd(3'd4, d); tests_run++;
    if (d !== 32'h8000_0008) begin tests_failed++; $display("FAIL fetch_wait_result: got %h expected %h", d, 32'h8000_0008); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    wr(3'd0, 32'h1234_5678);
    wr(3'd1, 32'h1234_5678);
    wr(3'd2, 32'h0000_0202);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    // Counts and sticky flags read 0; only the two empty indicators are set.
    rd(3'd3, d); tests_run++;
    if (d !== ST_BOTH_EMPTY) begin tests_failed++; $display("FAIL midreset_status: got %h expected %h", d, ST_BOTH_EMPTY); end
    rd(3'd2, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL midreset_control: got %h expected %h", d, 32'd0); end
    rd(3'd4, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL midreset_result: got %h expected %h", d, 32'd0); end
    repeat (8) @(posedge clk);
    rd(3'd2, d); tests_run++;
    if (d !== 32'd0) begin tests_failed++; $display("FAIL midreset_no_done: got %h expected %h", d, 32'd0); end
  endtask

  task automatic test_clear_go();
    logic [31:0] d;
    do_reset();
    wr(3'd0, 32'hAAAA_0001); wr(3'd0, 32'hAAAA_0002);
    wr(3'd1, 32'hAAAA_0001); wr(3'd1, 32'hAAAA_0002);
    wr(3'd2, 32'h0000_0106);
    repeat (6) @(posedge clk);
    rd(3'd3, d); tests_run++;
    if (d !== ST_BOTH_EMPTY) begin tests_failed++; $display("FAIL clear_go_status: got %h expected %h", d, ST_BOTH_EMPTY); end
    rd(3'd2, d); tests_run++;
    if (d[1:0] !== 2'b00) begin tests_failed++; $display("FAIL clear_go_done_busy: got %b expected %b", d[1:0], 2'b00); end
  endtask

  task automatic test_random_compare();
    logic [31:0] d, a, b, e;
    logic [31:0] qa[$], qb[$];
    int n, len, sel, match, consumed, nb;
    bit eq;
    for (int it = 0; it < 24; it++) begin
      wr(3'd2, 32'h0000_0004);
      qa.delete(); qb.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        a = $urandom;
        b = a;
        sel = $urandom_range(0, 7);
        if (sel < 4) b[8*sel +: 8] = b[8*sel +: 8] ^ 8'($urandom_range(1, 255));
        qa.push_back(a); qb.push_back(b);
        wr(3'd0, a);
        wr(3'd1, b);
      end
      len = $urandom_range(1, n);
      wr(3'd2, (32'(len) << 8) | 32'h2);
      wait_done("random");
      match = 0; eq = 1'b1; consumed = 0;
      for (int w = 0; w < len; w++) begin
        a = qa.pop_front();
        b = qb.pop_front();
        nb = 0;
        for (int k = 3; k >= 0; k--) begin
          if (a[8*k +: 8] != b[8*k +: 8]) break;
          nb++;
        end
        match += nb;
        consumed++;
        if (nb < 4) begin eq = 1'b0; break; end
      end
      e = (32'(eq) << 31) | 32'(match);
      rd(3'd4, d); tests_run++;
      if (d !== e) begin tests_failed++; $display("FAIL random_result%0d: got %h expected %h", it, d, e); end
      e = exp_status(n - consumed, n - consumed, 1'b0, 1'b0);
      rd(3'd3, d); tests_run++;
      if (d !== e) begin tests_failed++; $display("FAIL random_status%0d: got %h expected %h", it, d, e); end
      rd(3'd2, d); tests_run++;
      if (d[1:0] !== 2'b01) begin tests_failed++; $display("FAIL random_done_sticky%0d: got %b expected %b", it, d[1:0], 2'b01); end
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_equal_word();
    test_mismatch();
    test_len_zero();
    test_overflow_underflow();
    test_fetch_wait();
    test_reset_mid();
    test_clear_go();
    test_random_compare();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
